generic_delay_cfg_ctrl: RTL

Parametrised configuration controller for a bank of NumChannels programmable clock delay lines. It drives each line's clock-gate enable and delay code, and applies code changes glitch-free: gate the channel, drain, load the code, settle, re-enable. It sits between the link's register/calibration interface and the delay cells. It supersedes the fixed 4-bit, two-tap, ungated-update scheme with a configurable channel count, code width and update sequencing.

---
 rtl/generic_delay_cfg_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/generic_delay_cfg_ctrl.sv
// Configuration controller for a bank of programmable clock delay lines: code
// changes are applied glitch-free (gate, drain, load, settle, release).
// Optional broadcast updates are enabled with GENERIC_DELAY_CFG_BROADCAST_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a config request, all channels follow enable_i
// DRAIN  | target channel(s) gated, letting in-flight edges drain
// UPDATE | latched code written into target delay slice(s)
// SETTLE | new code applied, channel(s) still gated until the line settles
module generic_delay_cfg_ctrl #(
    parameter int NumChannels  = 2,
    parameter int DelayWidth   = 4,
    parameter int DrainCycles  = 4,
    parameter int SettleCycles = 8,
    parameter int ResetCode    = 0,
    localparam int ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              enable_i,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic [ChanWidth-1:0]              cfg_chan_i,
    input  logic [DelayWidth-1:0]             cfg_delay_i,
`ifdef GENERIC_DELAY_CFG_BROADCAST_EN
    input  logic                              cfg_bcast_i,
`endif
    output logic                              cfg_done_o,
    output logic                              cfg_err_o,
    output logic [NumChannels-1:0]            enable_o,
    output logic [NumChannels*DelayWidth-1:0] delay_o,
    output logic                              busy_o
);

    localparam int MaxCycles = (DrainCycles > SettleCycles) ? DrainCycles : SettleCycles;
    localparam int CntWidth  = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    localparam logic [DelayWidth-1:0] ResetCodeW = DelayWidth'(ResetCode);
    localparam logic [CntWidth-1:0]   DrainLoad  = CntWidth'(DrainCycles - 1);
    localparam logic [CntWidth-1:0]   SettleLoad = CntWidth'(SettleCycles - 1);

    logic [1:0]                        state_q, state_d;
    logic [CntWidth-1:0]               cnt_q, cnt_d;
    logic [NumChannels-1:0]            mask_q, mask_d;
    logic [DelayWidth-1:0]             code_q, code_d;
    logic [NumChannels-1:0]            enable_q, enable_d;
    logic [NumChannels*DelayWidth-1:0] delay_q, delay_d;
    logic                              done_q, done_d;
    logic                              err_q, err_d;

    logic                   handshake;
    logic [NumChannels-1:0] chan_mask;
    logic [NumChannels-1:0] code_eq;
    logic                   in_range;
    logic                   req_ok;
    logic                   req_nop;
    logic [NumChannels-1:0] req_mask;

    assign cfg_ready_o = (state_q == IDLE);
    assign handshake   = cfg_valid_i & cfg_ready_o;

    // An out-of-range index matches no channel, so the one-hot decode doubles as the range check.
    always_comb begin
        chan_mask = '0;
        code_eq   = '0;
        for (int c = 0; c < NumChannels; c++) begin
            chan_mask[c] = (cfg_chan_i == ChanWidth'(c));
            code_eq[c]   = (delay_q[c*DelayWidth +: DelayWidth] == cfg_delay_i);
        end
    end

    assign in_range = |chan_mask;

`ifdef GENERIC_DELAY_CFG_BROADCAST_EN
    assign req_ok   = cfg_bcast_i | in_range;
    assign req_nop  = cfg_bcast_i ? (&code_eq) : (|(chan_mask & code_eq));
    assign req_mask = cfg_bcast_i ? {NumChannels{1'b1}} : chan_mask;
`else
    assign req_ok   = in_range;
    assign req_nop  = |(chan_mask & code_eq);
    assign req_mask = chan_mask;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        code_d  = code_q;
        delay_d = delay_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (!req_ok) begin
                        err_d = 1'b1;
                    end else if (req_nop) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = DrainLoad;
                        mask_d  = req_mask;
                        code_d  = cfg_delay_i;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            UPDATE: begin
                for (int c = 0; c < NumChannels; c++) begin
                    if (mask_q[c]) begin
                        delay_d[c*DelayWidth +: DelayWidth] = code_q;
                    end
                end
                state_d = SETTLE;
                cnt_d   = SettleLoad;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
            end
        endcase
    end

    // Gated channels are forced low; everyone else, including a channel just released, takes enable_i.
    assign enable_d = {NumChannels{enable_i}} & ~mask_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            code_q   <= '0;
            enable_q <= '0;
            delay_q  <= {NumChannels{ResetCodeW}};
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            code_q   <= code_d;
            enable_q <= enable_d;
            delay_q  <= delay_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign enable_o   = enable_q;
    assign delay_o    = delay_q;
    assign cfg_done_o = done_q;
    assign cfg_err_o  = err_q;
    assign busy_o     = (state_q != IDLE);

endmodule
